// File: rtl/kfmmc_command_sequencer_pkg.sv
// Shared encodings and frame constants for the KFMMC command sequencer.
package kfmmc_command_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_ISSUE,
        ST_RX_ISSUE,
        ST_XFER,
        ST_GAP,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_TX,
        PH_RX,
        PH_GAP
    } seq_phase_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_ARM,
        HS_WAIT
    } hs_state_t;

    localparam logic [1:0]  CMD_START_BITS = 2'b01;
    localparam int unsigned FRAME_BYTES    = 6;
    localparam logic [7:0]  GAP_BYTE       = 8'hFF;

    // Byte of the 6-byte command frame selected by its position.
    function automatic logic [7:0] frame_byte(
        input logic [2:0]  idx,
        input logic [5:0]  cmd_index,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        case (idx)
            3'd0:    frame_byte = {CMD_START_BITS, cmd_index};
            3'd1:    frame_byte = arg[31:24];
            3'd2:    frame_byte = arg[23:16];
            3'd3:    frame_byte = arg[15:8];
            3'd4:    frame_byte = arg[7:0];
            default: frame_byte = {crc, 1'b1};
        endcase
    endfunction

endpackage

// File: rtl/kfmmc_command_sequencer_byte_handshake.sv
// Per-byte engine handshake: one arm cycle, then wait for in_connecting to fall.
module kfmmc_command_sequencer_byte_handshake
    import kfmmc_command_sequencer_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic issue_c,
    input  logic mmc_in_connecting,
    input  logic mmc_timeout_interrupt,
    output logic done_c,
    output logic timeout_c
);

    hs_state_t state_q;
    hs_state_t state_d;

    // Next-state and completion detect.
    always_comb begin
        state_d = state_q;
        done_c  = 1'b0;
        case (state_q)
            HS_IDLE: if (issue_c) state_d = HS_ARM;
            HS_ARM:  state_d = HS_WAIT;
            HS_WAIT: begin
                if (!mmc_in_connecting) begin
                    done_c  = 1'b1;
                    state_d = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    assign timeout_c = done_c & mmc_timeout_interrupt;

    // Handshake state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= HS_IDLE;
        else       state_q <= state_d;
    end

endmodule

// File: rtl/kfmmc_command_sequencer.sv
// Sequences one MMC/SD CMD-line transaction: frame, optional response, Ncc gap.
module kfmmc_command_sequencer
    import kfmmc_command_sequencer_pkg::*;
#(
    parameter int unsigned RESP_MAX_BYTES = 17,
    parameter int unsigned NCC_BYTES      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_argument,
    input  logic [4:0]  response_bytes,
    output logic        busy,
    output logic        cmd_done,
    output logic        cmd_timeout,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic [4:0]  resp_index,
    output logic        mmc_start_communication,
    output logic        mmc_command_io,
    output logic        mmc_check_command_start_bit,
    output logic        mmc_clear_command_crc,
    output logic        mmc_clear_command_interrupt,
    output logic        mmc_mask_command_interrupt,
    output logic        mmc_mask_data_interrupt,
    output logic        mmc_set_send_command,
    output logic [7:0]  mmc_send_command,
    input  logic [7:0]  mmc_received_response,
    input  logic [6:0]  mmc_send_command_crc,
    input  logic        mmc_in_connecting,
    input  logic        mmc_sent_command_interrupt,
    input  logic        mmc_received_response_interrupt,
    input  logic        mmc_timeout_interrupt
);

    localparam int unsigned GAP_W     = $clog2(NCC_BYTES + 2);
    localparam logic [2:0]  LAST_BYTE = 3'(FRAME_BYTES - 1);

    seq_state_t state_q, state_d;
    seq_phase_t phase_q, phase_d;
    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic [4:0]       rx_cnt_q, rx_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [5:0]       index_q, index_d;
    logic [31:0]      arg_q, arg_d;
    logic [4:0]       rbytes_q, rbytes_d;
    logic busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic rvalid_q, rvalid_d;
    logic [7:0] rdata_q, rdata_d;
    logic [4:0] rindex_q, rindex_d;
    logic start_q, start_d, io_q, io_d, csb_q, csb_d, clr_crc_q, clr_crc_d;
    logic clr_int_q, clr_int_d, mask_q, mask_d, set_send_q, set_send_d;
    logic [7:0] send_q, send_d;

    logic hs_issue_c, hs_done_c, hs_timeout_c;
    logic unused_irq_c;

    // The per-byte interrupt flags are implied by the in_connecting fall.
    assign unused_irq_c = mmc_sent_command_interrupt ^ mmc_received_response_interrupt;

    kfmmc_command_sequencer_byte_handshake u_handshake (
        .clock                 (clock),
        .reset                 (reset),
        .issue_c               (hs_issue_c),
        .mmc_in_connecting     (mmc_in_connecting),
        .mmc_timeout_interrupt (mmc_timeout_interrupt),
        .done_c                (hs_done_c),
        .timeout_c             (hs_timeout_c)
    );

    // Transaction sequencing, byte selection and strobe generation.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        index_d    = index_q;
        arg_d      = arg_q;
        rbytes_d   = rbytes_q;
        busy_d     = busy_q;
        timeout_d  = timeout_q;
        rdata_d    = rdata_q;
        rindex_d   = rindex_q;
        io_d       = io_q;
        mask_d     = mask_q;
        send_d     = send_q;
        done_d     = 1'b0;
        rvalid_d   = 1'b0;
        start_d    = 1'b0;
        csb_d      = 1'b0;
        clr_crc_d  = 1'b0;
        clr_int_d  = 1'b0;
        set_send_d = 1'b0;
        hs_issue_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mask_d = 1'b1;
                if (cmd_start) begin
                    timeout_d  = 1'b0;
                    index_d    = cmd_index;
                    arg_d      = cmd_argument;
                    rbytes_d   = (32'(response_bytes) > RESP_MAX_BYTES) ?
                                 5'(RESP_MAX_BYTES) : response_bytes;
                    busy_d     = 1'b1;
                    byte_cnt_d = 3'd0;
                    rx_cnt_d   = 5'd0;
                    gap_cnt_d  = '0;
                    phase_d    = PH_TX;
                    state_d    = ST_TX_ISSUE;
                end
            end
            ST_TX_ISSUE: begin
                start_d    = 1'b1;
                clr_int_d  = 1'b1;
                io_d       = 1'b0;
                set_send_d = 1'b1;
                mask_d     = 1'b0;
                clr_crc_d  = (byte_cnt_q == 3'd0);
                send_d     = frame_byte(byte_cnt_q, index_q, arg_q, mmc_send_command_crc);
                hs_issue_c = 1'b1;
                state_d    = ST_XFER;
            end
            ST_RX_ISSUE: begin
                start_d    = 1'b1;
                clr_int_d  = 1'b1;
                io_d       = 1'b1;
                mask_d     = 1'b0;
                csb_d      = (rx_cnt_q == 5'd0);
                hs_issue_c = 1'b1;
                state_d    = ST_XFER;
            end
            ST_XFER: begin
                if (hs_done_c) begin
                    if (phase_q != PH_GAP && hs_timeout_c) begin
                        timeout_d = 1'b1;
                        phase_d   = PH_GAP;
                        state_d   = ST_GAP;
                    end else begin
                        case (phase_q)
                            PH_TX: begin
                                if (byte_cnt_q < LAST_BYTE) begin
                                    byte_cnt_d = byte_cnt_q + 3'd1;
                                    state_d    = ST_TX_ISSUE;
                                end else if (rbytes_q != 5'd0) begin
                                    phase_d = PH_RX;
                                    state_d = ST_RX_ISSUE;
                                end else begin
                                    phase_d = PH_GAP;
                                    state_d = ST_GAP;
                                end
                            end
                            PH_RX: begin
                                rvalid_d = 1'b1;
                                rdata_d  = mmc_received_response;
                                rindex_d = rx_cnt_q;
                                rx_cnt_d = rx_cnt_q + 5'd1;
                                if (({1'b0, rx_cnt_q} + 6'd1) < {1'b0, rbytes_q}) begin
                                    state_d = ST_RX_ISSUE;
                                end else begin
                                    phase_d = PH_GAP;
                                    state_d = ST_GAP;
                                end
                            end
                            default: state_d = ST_GAP;
                        endcase
                    end
                end
            end
            ST_GAP: begin
                if (32'(gap_cnt_q) >= NCC_BYTES) begin
                    state_d = ST_DONE;
                end else begin
                    start_d    = 1'b1;
                    clr_int_d  = 1'b1;
                    io_d       = 1'b0;
                    set_send_d = 1'b1;
                    send_d     = GAP_BYTE;
                    gap_cnt_d  = gap_cnt_q + GAP_W'(1);
                    hs_issue_c = 1'b1;
                    state_d    = ST_XFER;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                mask_d  = 1'b1;
                io_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_TX;
            byte_cnt_q <= 3'd0;
            rx_cnt_q   <= 5'd0;
            gap_cnt_q  <= '0;
            index_q    <= 6'd0;
            arg_q      <= 32'd0;
            rbytes_q   <= 5'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 8'd0;
            rindex_q   <= 5'd0;
            start_q    <= 1'b0;
            io_q       <= 1'b1;
            csb_q      <= 1'b0;
            clr_crc_q  <= 1'b0;
            clr_int_q  <= 1'b0;
            mask_q     <= 1'b1;
            set_send_q <= 1'b0;
            send_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            index_q    <= index_d;
            arg_q      <= arg_d;
            rbytes_q   <= rbytes_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rindex_q   <= rindex_d;
            start_q    <= start_d;
            io_q       <= io_d;
            csb_q      <= csb_d;
            clr_crc_q  <= clr_crc_d;
            clr_int_q  <= clr_int_d;
            mask_q     <= mask_d;
            set_send_q <= set_send_d;
            send_q     <= send_d;
        end
    end

    assign busy                        = busy_q;
    assign cmd_done                    = done_q;
    assign cmd_timeout                 = timeout_q;
    assign resp_valid                  = rvalid_q;
    assign resp_data                   = rdata_q;
    assign resp_index                  = rindex_q;
    assign mmc_start_communication     = start_q;
    assign mmc_command_io              = io_q;
    assign mmc_check_command_start_bit = csb_q;
    assign mmc_clear_command_crc       = clr_crc_q;
    assign mmc_clear_command_interrupt = clr_int_q;
    assign mmc_mask_command_interrupt  = mask_q;
    assign mmc_mask_data_interrupt     = 1'b1;
    assign mmc_set_send_command        = set_send_q;
    assign mmc_send_command            = send_q;

endmodule

// File: tb/tb_kfmmc_command_sequencer.sv
// Bench for kfmmc_command_sequencer with a small byte-engine model and scoreboard queues.
module tb_kfmmc_command_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_argument = 32'd0;
    logic [4:0]  response_bytes = 5'd0;
    logic        busy, cmd_done, cmd_timeout, resp_valid;
    logic [7:0]  resp_data;
    logic [4:0]  resp_index;
    logic        mmc_start_communication, mmc_command_io, mmc_check_command_start_bit;
    logic        mmc_clear_command_crc, mmc_clear_command_interrupt;
    logic        mmc_mask_command_interrupt, mmc_mask_data_interrupt;
    logic        mmc_set_send_command;
    logic [7:0]  mmc_send_command;

    // Engine model state
    logic [7:0]  eng_rx_data;
    logic [6:0]  eng_crc;
    logic        eng_in_conn, eng_sent, eng_rcv, eng_to, eng_is_rx;
    logic [1:0]  eng_cnt;
    logic [4:0]  eng_rx_ptr;
    logic [7:0]  eng_resp [0:31];
    logic        eng_timeout_rx = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0]  exp_tx[$];
    logic [12:0] exp_resp[$];
    logic [47:0] r8_resp = 48'h08_00_00_01_AA_13;
    bit          stopped;

    always #5 clock = ~clock;

    kfmmc_command_sequencer dut (
        .clock                           (clock),
        .reset                           (reset),
        .cmd_start                       (cmd_start),
        .cmd_index                       (cmd_index),
        .cmd_argument                    (cmd_argument),
        .response_bytes                  (response_bytes),
        .busy                            (busy),
        .cmd_done                        (cmd_done),
        .cmd_timeout                     (cmd_timeout),
        .resp_valid                      (resp_valid),
        .resp_data                       (resp_data),
        .resp_index                      (resp_index),
        .mmc_start_communication         (mmc_start_communication),
        .mmc_command_io                  (mmc_command_io),
        .mmc_check_command_start_bit     (mmc_check_command_start_bit),
        .mmc_clear_command_crc           (mmc_clear_command_crc),
        .mmc_clear_command_interrupt     (mmc_clear_command_interrupt),
        .mmc_mask_command_interrupt      (mmc_mask_command_interrupt),
        .mmc_mask_data_interrupt         (mmc_mask_data_interrupt),
        .mmc_set_send_command            (mmc_set_send_command),
        .mmc_send_command                (mmc_send_command),
        .mmc_received_response           (eng_rx_data),
        .mmc_send_command_crc            (eng_crc),
        .mmc_in_connecting               (eng_in_conn),
        .mmc_sent_command_interrupt      (eng_sent),
        .mmc_received_response_interrupt (eng_rcv),
        .mmc_timeout_interrupt           (eng_to)
    );

    function automatic logic [6:0] crc7_upd(input logic [6:0] c, input logic [7:0] b);
        logic [6:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[6] ^ b[i];
            r  = {r[5:0], 1'b0};
            if (fb) r = r ^ 7'h09;
        end
        return r;
    endfunction

    // Byte engine: busy for three cycles per byte, CRC7 over transmitted bytes.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            eng_in_conn <= 1'b0; eng_cnt <= 2'd0; eng_crc <= 7'd0;
            eng_sent <= 1'b0; eng_rcv <= 1'b0; eng_to <= 1'b0;
            eng_rx_data <= 8'd0; eng_is_rx <= 1'b0; eng_rx_ptr <= 5'd0;
        end else if (mmc_start_communication) begin
            if (mmc_clear_command_interrupt) begin
                eng_sent <= 1'b0; eng_rcv <= 1'b0; eng_to <= 1'b0;
            end
            eng_in_conn <= 1'b1;
            eng_cnt     <= 2'd2;
            eng_is_rx   <= mmc_command_io;
            if (mmc_clear_command_crc) eng_rx_ptr <= 5'd0;
            if (!mmc_command_io)
                eng_crc <= crc7_upd(mmc_clear_command_crc ? 7'd0 : eng_crc, mmc_send_command);
        end else if (eng_in_conn) begin
            if (eng_cnt == 2'd0) begin
                eng_in_conn <= 1'b0;
                if (eng_is_rx) begin
                    if (eng_timeout_rx) eng_to <= 1'b1;
                    else                eng_rcv <= 1'b1;
                    eng_rx_data <= eng_resp[eng_rx_ptr];
                    eng_rx_ptr  <= eng_rx_ptr + 5'd1;
                end else begin
                    eng_sent <= 1'b1;
                end
            end else begin
                eng_cnt <= eng_cnt - 2'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctl"}, 32'({busy, cmd_done, cmd_timeout, resp_valid,
                                  mmc_start_communication, mmc_command_io,
                                  mmc_check_command_start_bit, mmc_clear_command_crc,
                                  mmc_clear_command_interrupt, mmc_mask_command_interrupt,
                                  mmc_mask_data_interrupt, mmc_set_send_command}), 32'h046);
        check({tag, "_data"}, 32'({resp_index, resp_data, mmc_send_command}), 32'd0);
    endtask

    task automatic push_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) exp_tx.push_back(f[47 - 8*i -: 8]);
        exp_tx.push_back(8'hFF);
    endtask

    task automatic set_resp(input int i, input logic [7:0] b);
        eng_resp[i] = b;
        exp_resp.push_back({5'(i), b});
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [4:0] rb);
        @(negedge clock);
        cmd_index = idx; cmd_argument = arg; response_bytes = rb; cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        check("busy_set", 32'(busy), 32'd1);
        check("timeout_clr", 32'(cmd_timeout), 32'd0);
    endtask

    // Watches the engine interface and response stream until cmd_done (bounded).
    task automatic run_monitor(input int poke_byte, input int stop_after_resp,
                               input int exp_rx_starts, output bit stop_flag);
        int k = 0;
        int rx = 0;
        int nresp = 0;
        bit done = 1'b0;
        logic [7:0]  eb;
        logic [12:0] er;
        stop_flag = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done && !stop_flag; cyc++) begin
            @(negedge clock);
            if (cmd_start) cmd_start = 1'b0;
            if (mmc_start_communication) begin
                check("clr_int", 32'(mmc_clear_command_interrupt), 32'd1);
                check("mask_active", 32'(mmc_mask_command_interrupt), 32'd0);
                if (!mmc_command_io) begin
                    if (exp_tx.size() == 0) begin
                        check("tx_extra", 32'(mmc_start_communication), 32'd0);
                    end else begin
                        eb = exp_tx.pop_front();
                        check($sformatf("tx_byte%0d", k), 32'(mmc_send_command), 32'(eb));
                    end
                    check("set_send", 32'(mmc_set_send_command), 32'd1);
                    check("clr_crc", 32'(mmc_clear_command_crc), 32'(k == 0));
                    if (k == poke_byte) begin
                        cmd_start = 1'b1; cmd_index = 6'h3F;
                        cmd_argument = 32'hDEADBEEF; response_bytes = 5'd17;
                    end
                    k++;
                end else begin
                    check("start_bit_arm", 32'(mmc_check_command_start_bit), 32'(rx == 0));
                    check("set_send_rx", 32'(mmc_set_send_command), 32'd0);
                    rx++;
                end
            end
            if (resp_valid) begin
                if (exp_resp.size() == 0) begin
                    check("resp_extra", 32'(resp_valid), 32'd0);
                end else begin
                    er = exp_resp.pop_front();
                    check($sformatf("resp%0d", nresp), 32'({resp_index, resp_data}), 32'(er));
                end
                nresp++;
                if (nresp == stop_after_resp) stop_flag = 1'b1;
            end
            if (cmd_done) begin
                done = 1'b1;
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
        if (!stop_flag) begin
            check("done_seen", 32'(done), 32'd1);
            check("tx_left", 32'(exp_tx.size()), 32'd0);
            check("resp_left", 32'(exp_resp.size()), 32'd0);
            check("rx_starts", 32'(rx), 32'(exp_rx_starts));
            @(negedge clock);
            check("done_pulse", 32'(cmd_done), 32'd0);
            check("mask_restored", 32'(mmc_mask_command_interrupt), 32'd1);
            check("io_idle", 32'(mmc_command_io), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) eng_resp[i] = 8'h00;
        #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_reset_values("rst0");
        reset = 1'b0;
        @(negedge clock);
        check("idle_busy", 32'(busy), 32'd0);

        // CMD0, no response
        push_frame(48'h40_00_00_00_00_95);
        start_cmd(6'd0, 32'd0, 5'd0);
        run_monitor(-1, -1, 0, stopped);
        check("cmd0_timeout", 32'(cmd_timeout), 32'd0);

        // CMD8 with R7 response
        push_frame(48'h48_00_00_01_AA_87);
        for (int i = 0; i < 6; i++) set_resp(i, r8_resp[47 - 8*i -: 8]);
        start_cmd(6'd8, 32'h0000_01AA, 5'd6);
        run_monitor(-1, -1, 6, stopped);

        // CMD2 with R2 response
        push_frame(48'h42_00_00_00_00_4D);
        for (int i = 0; i < 17; i++) set_resp(i, 8'(i * 13 + 1));
        start_cmd(6'd2, 32'd0, 5'd17);
        run_monitor(-1, -1, 17, stopped);

        // Oversized response length is clamped to 17
        push_frame(48'h42_00_00_00_00_4D);
        for (int i = 0; i < 17; i++) set_resp(i, 8'(i * 7 + 3));
        start_cmd(6'd2, 32'd0, 5'd31);
        run_monitor(-1, -1, 17, stopped);

        // Timeout on the first receive byte
        eng_timeout_rx = 1'b1;
        push_frame(48'h48_00_00_01_AA_87);
        start_cmd(6'd8, 32'h0000_01AA, 5'd6);
        run_monitor(-1, -1, 1, stopped);
        check("timeout_set", 32'(cmd_timeout), 32'd1);
        eng_timeout_rx = 1'b0;

        // Next command clears the sticky timeout (checked in start_cmd)
        push_frame(48'h40_00_00_00_00_95);
        start_cmd(6'd0, 32'd0, 5'd0);
        run_monitor(-1, -1, 0, stopped);
        check("timeout_after", 32'(cmd_timeout), 32'd0);

        // cmd_start during byte 3 is ignored
        push_frame(48'h48_00_00_01_AA_87);
        start_cmd(6'd8, 32'h0000_01AA, 5'd0);
        run_monitor(3, -1, 0, stopped);
        repeat (3) @(negedge clock);
        check("busy_after_poke", 32'(busy), 32'd0);

        // Reset in the middle of the receive phase
        push_frame(48'h48_00_00_01_AA_87);
        for (int i = 0; i < 6; i++) set_resp(i, r8_resp[47 - 8*i -: 8]);
        start_cmd(6'd8, 32'h0000_01AA, 5'd6);
        run_monitor(-1, 2, 6, stopped);
        check("reached_rx", 32'(stopped), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_values("rst_mid");
        exp_tx.delete();
        exp_resp.delete();
        @(negedge clock);
        @(negedge clock);
        check("no_done_in_reset", 32'(cmd_done), 32'd0);
        reset = 1'b0;

        // Normal command after the abort
        push_frame(48'h40_00_00_00_00_95);
        start_cmd(6'd0, 32'd0, 5'd0);
        run_monitor(-1, -1, 0, stopped);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
